// File: rtl/seg_scan_driver.sv
// Multiplexed six-digit seven-segment scanner with dead-time blanking,
// per-frame snapshot of display data, PWM brightness and per-digit blink.
module seg_scan_driver #(
    parameter int unsigned DIV          = 50000,
    parameter int unsigned DEAD         = 500,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [47:0] frame_in,
    input  logic [2:0]  brightness,
    input  logic [5:0]  blink_mask,
    output logic [7:0]  seg_n,
    output logic [5:0]  dig_n,
    output logic        frame_tick
);

    localparam int unsigned CW = $clog2(DIV);
    // Room for the (DIV-DEAD)*8 comparison without truncation.
    localparam int unsigned PW = CW + 4;
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned LAST_DIGIT = 5;

    logic [CW-1:0]     pre_cnt,    pre_cnt_nxt;
    logic [2:0]        dig_idx,    dig_idx_nxt;
    logic [5:0][7:0]   shadow,     shadow_nxt;
    logic [2:0]        shadow_bri, shadow_bri_nxt;
    logic [FW-1:0]     frame_cnt,  frame_cnt_nxt;
    logic              blink_phase, blink_phase_nxt;
    logic [7:0]        seg_n_nxt;
    logic [5:0]        dig_n_nxt;
    logic              frame_tick_nxt;

    logic              slot_end;
    logic              frame_end;
    logic              duty_on;
    logic              blanked;
    logic              lit;
    logic [PW-1:0]     on_offset;
    logic [PW-1:0]     on_limit;

    // Scan state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt     <= '0;
            dig_idx     <= '0;
            shadow      <= '0;
            shadow_bri  <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            seg_n       <= 8'hFF;
            dig_n       <= 6'h3F;
            frame_tick  <= 1'b0;
        end else begin
            pre_cnt     <= pre_cnt_nxt;
            dig_idx     <= dig_idx_nxt;
            shadow      <= shadow_nxt;
            shadow_bri  <= shadow_bri_nxt;
            frame_cnt   <= frame_cnt_nxt;
            blink_phase <= blink_phase_nxt;
            seg_n       <= seg_n_nxt;
            dig_n       <= dig_n_nxt;
            frame_tick  <= frame_tick_nxt;
        end
    end

    // Slot timing, brightness window and blink gating for the current slot.
    always_comb begin
        slot_end  = (pre_cnt == CW'(DIV - 1));
        frame_end = slot_end && (dig_idx == 3'(LAST_DIGIT));
        on_offset = PW'(pre_cnt) - PW'(DEAD);
        on_limit  = PW'(DIV - DEAD) * (PW'(shadow_bri) + PW'(1));
        duty_on   = (pre_cnt >= CW'(DEAD)) && ((on_offset << 3) < on_limit);
        blanked   = blink_phase && blink_mask[dig_idx];
        lit       = en && duty_on && !blanked;
    end

    // Next-state for counters, snapshot, blink phase and outputs.
    always_comb begin
        pre_cnt_nxt     = pre_cnt;
        dig_idx_nxt     = dig_idx;
        shadow_nxt      = shadow;
        shadow_bri_nxt  = shadow_bri;
        frame_cnt_nxt   = frame_cnt;
        blink_phase_nxt = blink_phase;
        seg_n_nxt       = 8'hFF;
        dig_n_nxt       = 6'h3F;
        frame_tick_nxt  = 1'b0;

        if (!en) begin
            // Idle: park the scan at digit 0 and keep the shadow tracking the input.
            pre_cnt_nxt     = '0;
            dig_idx_nxt     = '0;
            frame_cnt_nxt   = '0;
            blink_phase_nxt = 1'b0;
            shadow_nxt      = frame_in;
            shadow_bri_nxt  = brightness;
        end else begin
            pre_cnt_nxt = slot_end ? '0 : pre_cnt + CW'(1);
            if (slot_end) begin
                dig_idx_nxt = frame_end ? 3'd0 : dig_idx + 3'd1;
            end
            if (frame_end) begin
                shadow_nxt     = frame_in;
                shadow_bri_nxt = brightness;
                frame_tick_nxt = 1'b1;
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt_nxt   = '0;
                    blink_phase_nxt = ~blink_phase;
                end else begin
                    frame_cnt_nxt = frame_cnt + FW'(1);
                end
            end
            if (lit) begin
                seg_n_nxt = ~shadow[dig_idx];
                dig_n_nxt = ~(6'd1 << dig_idx);
            end
        end
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter DIV, default 50000: clock cycles per digit slot; legal range DIV >= 16.
REQ-002 Parameter DEAD, default 500: blanking cycles at the start of each slot; legal range 1 <= DEAD < DIV/2.
REQ-003 Parameter BLINK_FRAMES, default 64: frames per blink half-period; legal range >= 1.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 en  input  1  scan enable.
REQ-008 frame_in  input  48  six 8-bit segment patterns from the display mux; digit k = bits [8k+7:8k]; 1 = segment lit.
REQ-009 brightness  input  3  duty level 0..7.
REQ-010 blink_mask  input  6  bit k = 1 makes digit k blink.
REQ-011 seg_n  output  8  active-low segment drive; bit i = ~pattern bit i.
REQ-012 dig_n  output  6  active-low digit enables; at most one bit low at any time.
REQ-013 frame_tick  output  1  one-cycle pulse when a new frame snapshot is taken.

Function
REQ-014 pre_cnt SHALL count 0..DIV-1 and wrap; slot_end = (pre_cnt == DIV-1).
REQ-015 Digit index d SHALL advance 0->1->...->5->0 on slot_end; frame = 6 slots = 6*DIV cycles.
REQ-016 On slot_end with d == 5, shadow registers SHALL load frame_in and brightness, and frame_tick SHALL be 1 on the following cycle only.
REQ-017 Displayed data SHALL come only from the shadow registers; frame_in or brightness changes mid-frame have no visible effect until the next snapshot.
REQ-018 For pre_cnt < DEAD: dig_n = 6'h3F and seg_n = 8'hFF.
REQ-019 For pre_cnt >= DEAD and (pre_cnt-DEAD)*8 < (DIV-DEAD)*(shadow_brightness+1): dig_n[d] = 0 (others 1) and seg_n = ~shadow[8d+7:8d]; otherwise outputs are all-off.
REQ-020 Products in REQ-019 SHALL be computed at full width with no truncation; brightness 7 keeps the digit on for all DIV-DEAD cycles of the slot.
REQ-021 A frame counter SHALL toggle blink_phase after every BLINK_FRAMES frame_ticks, then restart at 0.
REQ-022 When blink_phase == 1 and blink_mask[d] == 1, the digit SHALL stay all-off for the whole slot; blink_mask is read live, not snapshotted.
REQ-023 seg_n, dig_n and frame_tick SHALL be registered, lagging the counter state that selects them by exactly one cycle.
REQ-024 While en == 0: pre_cnt, d, the frame counter and blink_phase held at 0; shadow loads frame_in and brightness every cycle; outputs all-off; no frame_tick.
REQ-025 After en rises, the first lit slot SHALL be digit 0, using the shadow value captured in the last en == 0 cycle.
REQ-026 Segment and digit outputs SHALL never be low during the transition between slots; the DEAD window guarantees this.

Reset
REQ-027 rst_n low SHALL immediately force: seg_n = 8'hFF, dig_n = 6'h3F, frame_tick = 0, pre_cnt = 0, d = 0, shadow = 0, shadow_brightness = 0, frame counter = 0, blink_phase = 0.
REQ-028 Reset asserted mid-slot SHALL abort the scan; after release, scanning restarts at digit 0, pre_cnt 0.

Verification (DIV=16, DEAD=2, BLINK_FRAMES=2)
REQ-029 Scan order: en=1, frame_in=48'h060504030201, brightness=7 -> slot d shows dig_n[d]=0 and seg_n=~(d+1) for pre_cnt 2..15; order 0..5; frame_tick every 96 cycles.
REQ-030 Snapshot: change frame_in to all 48'hFF...FF during digit 2 -> digits 2..5 still show old data; new data appears from digit 0 after the next frame_tick.
REQ-031 Duty: brightness=0 -> digit on for 2 cycles per slot (pre_cnt 2..3); brightness=3 -> 7 cycles (pre_cnt 2..8).
REQ-032 Blink: blink_mask=6'b000001 -> digit 0 lit in frames 0-1, dark in frames 2-3, lit in frames 4-5; other digits always lit.
REQ-033 Reset mid-scan: rst_n low at digit 3, pre_cnt 7 -> outputs 8'hFF/6'h3F in the same cycle; after release, digit 0 lights at pre_cnt 2 with seg_n = 8'hFF (shadow cleared) until the first snapshot.
REQ-034 Enable: en low mid-frame -> all-off on the next cycle; en high -> digit 0 lights DEAD+1 cycles later with the current frame_in.
